// File: rtl/bp_pkg.sv
// Shared types and constants for the BHT/BTB branch predictor.
// The 2-bit counter encoding doubles as the prediction: bit 1 set means taken.
package bp_pkg;

  localparam int BP_ADDR_W = 32;
  localparam int BP_TAG_W  = 8;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  // One BTB slot; the direction counter lives in a separate array so that it
  // can be reset independently of the tag/target payload.
  typedef struct packed {
    logic                 valid;
    logic [BP_TAG_W-1:0]  tag;
    logic [BP_ADDR_W-1:0] target;
  } btb_entry_t;

  localparam ctr_t CTR_INIT            = WNT;
  localparam ctr_t CTR_ALLOC_TAKEN     = WT;
  localparam ctr_t CTR_ALLOC_NOT_TAKEN = WNT;

  // Direction implied by a counter value.
  function automatic logic ctr_says_taken(input ctr_t c);
    return c[1];
  endfunction

endpackage

// File: rtl/bht_branch_predictor_if.sv
// Fetch/execute-facing bundle of the branch predictor.
//
// Handshake semantics: there is no back-pressure. fetch_pc is looked up every
// cycle and pred_* are valid combinationally in that cycle. resolve_valid is a
// single-cycle qualifier for all resolve_* fields; the predictor always accepts
// it (no ready). rst_out is a one-cycle registered pulse that qualifies
// redirect_pc; redirect_pc holds its last value otherwise. mispredict_count is
// always valid.
interface bht_branch_predictor_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] fetch_pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              pred_hit;
  logic              resolve_valid;
  logic [ADDR_W-1:0] resolve_pc;
  logic              resolve_taken;
  logic [ADDR_W-1:0] resolve_target;
  logic              resolve_pred_taken;
  logic [ADDR_W-1:0] resolve_pred_target;
  logic              rst_out;
  logic [ADDR_W-1:0] redirect_pc;
  logic [31:0]       mispredict_count;

  // Pipeline side: drives fetch PC and resolutions, consumes predictions.
  modport master (
    output fetch_pc, resolve_valid, resolve_pc, resolve_taken,
           resolve_target, resolve_pred_taken, resolve_pred_target,
    input  pred_taken, pred_target, pred_hit, rst_out, redirect_pc,
           mispredict_count
  );

  // Predictor side.
  modport slave (
    input  fetch_pc, resolve_valid, resolve_pc, resolve_taken,
           resolve_target, resolve_pred_taken, resolve_pred_target,
    output pred_taken, pred_target, pred_hit, rst_out, redirect_pc,
           mispredict_count
  );
endinterface

// File: rtl/bp_sat_counter.sv
// 2-bit saturating up/down counter next-state function used when training.
module bp_sat_counter
  import bp_pkg::*;
(
  input  ctr_t ctr_in,
  input  logic taken,
  output ctr_t ctr_out
);

  // Step toward taken or not-taken, sticking at the ends.
  always_comb begin
    ctr_out = ctr_in;
    case (ctr_in)
      SNT:     ctr_out = taken ? WNT : SNT;
      WNT:     ctr_out = taken ? WT  : SNT;
      WT:      ctr_out = taken ? ST  : WNT;
      ST:      ctr_out = taken ? ST  : WT;
      default: ctr_out = ctr_in;
    endcase
  end

endmodule

// File: rtl/bht_branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB plus 2-bit BHT, flop based.
// Lookup is combinational on fetch_pc; training and flush generation happen
// on the resolve interface from execute.
// Optional macro BP_GSHARE_EN: XOR a global history register into both the
// lookup and the update index (gshare). Undefined means PC-only indexing.
// Entry widths come from bp_pkg, so ADDR_W/TAG_W must track BP_ADDR_W/BP_TAG_W.
module bht_branch_predictor
  import bp_pkg::*;
#(
  parameter int ADDR_W = BP_ADDR_W,
  parameter int IDX_W  = 6,
  parameter int TAG_W  = BP_TAG_W
) (
  input  logic                   clk,
  input  logic                   rst_BF,
  bht_branch_predictor_if.slave  bus
);

  localparam int ENTRIES = 1 << IDX_W;

  btb_entry_t btb     [ENTRIES];
  ctr_t       ctr_tab [ENTRIES];

  logic [IDX_W-1:0]  fetch_idx;
  logic [IDX_W-1:0]  upd_idx;
  logic [TAG_W-1:0]  fetch_tag;
  logic [TAG_W-1:0]  upd_tag;
  btb_entry_t        fetch_entry;
  btb_entry_t        upd_entry;
  ctr_t              fetch_ctr;
  ctr_t              upd_ctr;
  ctr_t              upd_ctr_next;
  logic              fetch_hit;
  logic              upd_hit;
  logic              mispredict;
  logic [ADDR_W-1:0] redirect_next;

  logic              rst_out_q;
  logic [ADDR_W-1:0] redirect_q;
  logic [31:0]       count_q;

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr;

  // Global history: shift in every resolved outcome, never rolled back.
  always_ff @(posedge clk) begin
    if (rst_BF) begin
      ghr <= '0;
    end else if (bus.resolve_valid) begin
      ghr <= {ghr[IDX_W-2:0], bus.resolve_taken};
    end
  end

  assign fetch_idx = bus.fetch_pc[IDX_W+1:2] ^ ghr;
  assign upd_idx   = bus.resolve_pc[IDX_W+1:2] ^ ghr;
`else
  assign fetch_idx = bus.fetch_pc[IDX_W+1:2];
  assign upd_idx   = bus.resolve_pc[IDX_W+1:2];
`endif

  assign fetch_tag = bus.fetch_pc[IDX_W+2 +: TAG_W];
  assign upd_tag   = bus.resolve_pc[IDX_W+2 +: TAG_W];

  // Read ports see only registered contents: an update to the same index in
  // this cycle is not forwarded to the lookup.
  assign fetch_entry = btb[fetch_idx];
  assign fetch_ctr   = ctr_tab[fetch_idx];
  assign upd_entry   = btb[upd_idx];
  assign upd_ctr     = ctr_tab[upd_idx];

  assign fetch_hit = fetch_entry.valid && (fetch_entry.tag == fetch_tag);
  assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

  assign bus.pred_hit    = fetch_hit;
  assign bus.pred_taken  = fetch_hit && ctr_says_taken(fetch_ctr);
  assign bus.pred_target = bus.pred_taken ? fetch_entry.target
                                          : bus.fetch_pc + ADDR_W'(4);

  bp_sat_counter u_sat (
    .ctr_in  (upd_ctr),
    .taken   (bus.resolve_taken),
    .ctr_out (upd_ctr_next)
  );

  // A wrong direction, or a taken branch that went somewhere else, flushes.
  assign mispredict = bus.resolve_valid &&
                      ((bus.resolve_taken != bus.resolve_pred_taken) ||
                       (bus.resolve_taken &&
                        (bus.resolve_target != bus.resolve_pred_target)));

  assign redirect_next = bus.resolve_taken ? bus.resolve_target
                                           : bus.resolve_pc + ADDR_W'(4);

  // Table training: allocate on miss, otherwise nudge the counter and refresh
  // the target only when the branch was actually taken.
  always_ff @(posedge clk) begin
    if (rst_BF) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb[i].valid <= 1'b0;
        ctr_tab[i]   <= CTR_INIT;
      end
    end else if (bus.resolve_valid) begin
      if (upd_hit) begin
        ctr_tab[upd_idx] <= upd_ctr_next;
        if (bus.resolve_taken) begin
          btb[upd_idx].target <= bus.resolve_target;
        end
      end else begin
        btb[upd_idx] <= '{valid: 1'b1, tag: upd_tag,
                          target: bus.resolve_target};
        ctr_tab[upd_idx] <= bus.resolve_taken ? CTR_ALLOC_TAKEN
                                              : CTR_ALLOC_NOT_TAKEN;
      end
    end
  end

  // Flush pulse, redirect target and saturating mispredict counter.
  always_ff @(posedge clk) begin
    if (rst_BF) begin
      rst_out_q  <= 1'b0;
      redirect_q <= '0;
      count_q    <= '0;
    end else begin
      rst_out_q <= mispredict;
      if (mispredict) begin
        redirect_q <= redirect_next;
        if (count_q != 32'hFFFF_FFFF) begin
          count_q <= count_q + 32'd1;
        end
      end
    end
  end

  assign bus.rst_out          = rst_out_q;
  assign bus.redirect_pc      = redirect_q;
  assign bus.mispredict_count = count_q;

endmodule

// File: tb/tb_bht_branch_predictor.sv
// Self-checking bench for bht_branch_predictor: directed scenarios followed by
// random traffic, all checked against a table-level reference model.
module tb_bht_branch_predictor;

  localparam int IDX_W = 6;
  localparam int TAG_W = 8;
  localparam int N     = 1 << IDX_W;
  localparam int EW    = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_BF;
  always #5 clk = ~clk;

  bht_branch_predictor_if #(.ADDR_W(32)) bus ();

  bht_branch_predictor #(.ADDR_W(32), .IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .clk    (clk),
    .rst_BF (rst_BF),
    .bus    (bus)
  );

  // ---------------- scoreboard state ----------------
  // Layout: {check, pred_taken, pred_hit, pred_target, rst_out, redirect, count}
  logic [EW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  bit          m_valid  [N];
  int unsigned m_tag    [N];
  logic [31:0] m_target [N];
  int          m_ctr    [N];
  int unsigned m_ghr    = 0;
  bit          m_known  = 1'b0;
  logic        m_flush  = 1'b0;
  logic [31:0] m_redirect = '0;
  logic [31:0] m_count  = '0;

  function automatic int unsigned m_index(input logic [31:0] pc);
    int unsigned i;
    i = (pc >> 2) % N;
`ifdef BP_GSHARE_EN
    i = i ^ m_ghr;
`endif
    return i;
  endfunction

  function automatic int unsigned m_tagof(input logic [31:0] pc);
    return (pc >> (IDX_W + 2)) % (1 << TAG_W);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int unsigned i;
    i = m_index(pc);
    return m_valid[i] && (m_tag[i] == m_tagof(pc));
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[m_index(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_tgt(input logic [31:0] pc);
    return m_taken(pc) ? m_target[m_index(pc)] : pc + 32'd4;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_ghr      = 0;
    m_flush    = 1'b0;
    m_redirect = '0;
    m_count    = '0;
    m_known    = 1'b1;
  endtask

  // ---------------- driver ----------------
  // One clock cycle of stimulus: drive, record the expectation for this
  // cycle's sample point, then advance the model past this cycle's edge.
  task automatic step(input bit rst, input bit rv, input logic [31:0] fpc,
                      input logic [31:0] rpc, input bit rt,
                      input logic [31:0] rtgt, input bit rpt,
                      input logic [31:0] rptgt);
    bit          mis;
    int unsigned i;
    int unsigned t;
    @(posedge clk);
    #1;
    rst_BF                  = rst;
    bus.fetch_pc            = fpc;
    bus.resolve_valid       = rv;
    bus.resolve_pc          = rpc;
    bus.resolve_taken       = rt;
    bus.resolve_target      = rtgt;
    bus.resolve_pred_taken  = rpt;
    bus.resolve_pred_target = rptgt;
    exp_q.push_back({m_known, m_taken(fpc), m_hit(fpc), m_tgt(fpc),
                     m_flush, m_redirect, m_count});
    if (rst) begin
      m_reset();
    end else begin
      mis = rv && ((rt != rpt) || (rt && (rtgt != rptgt)));
      m_flush = mis;
      if (mis) begin
        m_redirect = rt ? rtgt : rpc + 32'd4;
        if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
      end
      if (rv) begin
        i = m_index(rpc);
        t = m_tagof(rpc);
        if (m_valid[i] && (m_tag[i] == t)) begin
          if (rt) begin
            m_ctr[i]    = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            m_target[i] = rtgt;
          end else begin
            m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
          end
        end else begin
          m_valid[i]  = 1'b1;
          m_tag[i]    = t;
          m_target[i] = rtgt;
          m_ctr[i]    = rt ? 2 : 1;
        end
        m_ghr = ((m_ghr << 1) | (rt ? 1 : 0)) % N;
      end
    end
  endtask

  task automatic idle(input logic [31:0] fpc);
    step(1'b0, 1'b0, fpc, '0, 1'b0, '0, 1'b0, '0);
  endtask

  // Resolve carrying the prediction the model would have made for it.
  task automatic resolve(input logic [31:0] pc, input bit taken,
                         input logic [31:0] tgt, input logic [31:0] fpc);
    bit          ppt;
    logic [31:0] pptgt;
    ppt   = m_taken(pc);
    pptgt = m_tgt(pc);
    step(1'b0, 1'b1, fpc, pc, taken, tgt, ppt, pptgt);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e[99]) begin
          checks++;
          if ({bus.pred_taken, bus.pred_hit, bus.pred_target} !== e[98:65]) begin
            failures++;
            $display("FAIL prediction @%0t pc=%h: got t=%b h=%b tgt=%h expected t=%b h=%b tgt=%h",
                     $time, bus.fetch_pc, bus.pred_taken, bus.pred_hit,
                     bus.pred_target, e[98], e[97], e[96:65]);
          end
          checks++;
          if ({bus.rst_out, bus.redirect_pc, bus.mispredict_count} !== e[64:0]) begin
            failures++;
            $display("FAIL flush_state @%0t: got rst_out=%b redirect=%h count=%0d expected rst_out=%b redirect=%h count=%0d",
                     $time, bus.rst_out, bus.redirect_pc, bus.mispredict_count,
                     e[64], e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    logic [31:0] pcs  [8];
    logic [31:0] tgts [4];
    logic [31:0] snap;
    logic [31:0] rpc;
    logic [31:0] rtgt;
    bit          rt;
    int          wait_cycles;

    pcs[0] = 32'h0000_0100; pcs[1] = 32'h0000_0200; pcs[2] = 32'h0000_0300;
    pcs[3] = 32'h0000_4100; pcs[4] = 32'h0000_0104; pcs[5] = 32'h0000_1108;
    pcs[6] = 32'h0000_23FC; pcs[7] = 32'hFFFF_FFFC;
    tgts[0] = 32'h0000_0080; tgts[1] = 32'h0000_1F00;
    tgts[2] = 32'h0000_0500; tgts[3] = 32'h0000_0010;

    rst_BF                  = 1'b1;
    bus.fetch_pc            = 32'h100;
    bus.resolve_valid       = 1'b0;
    bus.resolve_pc          = '0;
    bus.resolve_taken       = 1'b0;
    bus.resolve_target      = '0;
    bus.resolve_pred_taken  = 1'b0;
    bus.resolve_pred_target = '0;

    // 1. reset for two cycles
    step(1'b1, 1'b0, 32'h100, '0, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b0, 32'h100, '0, 1'b0, '0, 1'b0, '0);
    idle(32'h100);
    @(negedge clk);
    check("reset_pred_taken", 32'(bus.pred_taken), 32'd0);
    check("reset_pred_target", bus.pred_target, 32'h104);
    check("reset_rst_out", 32'(bus.rst_out), 32'd0);
    check("reset_count", bus.mispredict_count, 32'd0);

    // 2. first taken resolve mispredicts and allocates
    step(1'b0, 1'b1, 32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    idle(32'h100);
    @(negedge clk);
    check("t2_rst_out", 32'(bus.rst_out), 32'd1);
    check("t2_redirect", bus.redirect_pc, 32'h80);
    check("t2_count", bus.mispredict_count, 32'd1);
`ifndef BP_GSHARE_EN
    check("t2_pred_taken", 32'(bus.pred_taken), 32'd1);
    check("t2_pred_target", bus.pred_target, 32'h80);
`endif
    idle(32'h100);
    @(negedge clk);
    check("t2_pulse_one_cycle", 32'(bus.rst_out), 32'd0);

    // 3. loop branch: ten taken then one not-taken
    for (int k = 0; k < 10; k++) resolve(32'h200, 1'b1, 32'h1F0, pcs[$urandom_range(0, 7)]);
    resolve(32'h200, 1'b0, 32'h1F0, 32'h200);
    idle(32'h200);
    @(negedge clk);
    check("t3_rst_out", 32'(bus.rst_out), 32'd1);
    check("t3_redirect", bus.redirect_pc, 32'h204);
`ifndef BP_GSHARE_EN
    check("t3_count", bus.mispredict_count, 32'd3);
`endif

    // 4. aliasing: same index, different tag replaces the entry
    resolve(32'h100, 1'b1, 32'h80, 32'h300);
    idle(32'h100);
`ifndef BP_GSHARE_EN
    @(negedge clk);
    check("t4_hit_before_alias", 32'(bus.pred_hit), 32'd1);
`endif
    resolve(32'h4100, 1'b1, 32'h500, 32'h100);
    idle(32'h100);
`ifndef BP_GSHARE_EN
    @(negedge clk);
    check("t4_hit_after_alias", 32'(bus.pred_hit), 32'd0);
`endif

    // 5. back-to-back mispredicts, then one cut short by reset
    snap = m_count;
    step(1'b0, 1'b1, 32'h600, 32'h600, 1'b1, 32'h640, 1'b0, 32'h604);
    step(1'b0, 1'b1, 32'h700, 32'h700, 1'b1, 32'h740, 1'b0, 32'h704);
    @(negedge clk);
    check("t5_first_pulse", 32'(bus.rst_out), 32'd1);
    check("t5_first_redirect", bus.redirect_pc, 32'h640);
    idle(32'h100);
    @(negedge clk);
    check("t5_second_pulse", 32'(bus.rst_out), 32'd1);
    check("t5_second_redirect", bus.redirect_pc, 32'h740);
    check("t5_count_plus2", bus.mispredict_count, snap + 32'd2);
    step(1'b0, 1'b1, 32'h800, 32'h800, 1'b1, 32'h840, 1'b0, 32'h804);
    step(1'b1, 1'b1, 32'h900, 32'h900, 1'b1, 32'h940, 1'b0, 32'h904);
    idle(32'h900);
    @(negedge clk);
    check("t5_pulse_suppressed", 32'(bus.rst_out), 32'd0);
    check("t5_count_cleared", bus.mispredict_count, 32'd0);
    check("t5_redirect_cleared", bus.redirect_pc, 32'd0);
    check("t5_table_cleared", 32'(bus.pred_hit), 32'd0);

    // 6. alternating branch at 0x300
    for (int k = 0; k < 16; k++) resolve(32'h300, (k % 2) == 0, 32'h2F0, 32'h300);
    snap = m_count;
    for (int k = 0; k < 8; k++) resolve(32'h300, (k % 2) == 0, 32'h2F0, 32'h300);
    idle(32'h300);
    @(negedge clk);
`ifdef BP_GSHARE_EN
    check("t6_no_mispredicts", bus.mispredict_count, snap);
`else
    check("t6_mispredicts_continue", bus.mispredict_count, snap + 32'd8);
`endif

    // 7. random traffic
    for (int k = 0; k < 600; k++) begin
      rpc  = pcs[$urandom_range(0, 7)];
      rt   = $urandom_range(0, 1) == 1;
      rtgt = tgts[$urandom_range(0, 3)];
      if ($urandom_range(0, 99) == 0) begin
        step(1'b1, $urandom_range(0, 1) == 1, pcs[$urandom_range(0, 7)],
             rpc, rt, rtgt, 1'b0, '0);
      end else if ($urandom_range(0, 9) < 3) begin
        idle(pcs[$urandom_range(0, 7)]);
      end else if ($urandom_range(0, 4) == 0) begin
        step(1'b0, 1'b1, pcs[$urandom_range(0, 7)], rpc, rt, rtgt,
             $urandom_range(0, 1) == 1, tgts[$urandom_range(0, 3)]);
      end else begin
        resolve(rpc, rt, rtgt, pcs[$urandom_range(0, 7)]);
      end
    end
    idle(32'h100);
    idle(32'h200);

    // drain the scoreboard with a bounded wait
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
